// File: rtl/exu_muldiv_if.sv
// Execute-stage request/result bundle between the issue pipeline and the multiply/divide unit.
// master = pipeline side, slave = exu_muldiv.
interface exu_muldiv_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            busy;

    modport master (
        output in_valid, op, rs1_data, rs2_data, rd_in, flush, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    modport slave (
        input  in_valid, op, rs1_data, rs2_data, rd_in, flush, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface

// File: rtl/exu_muldiv.sv
// RV32M multiply/divide unit: shift-add multiply, restoring divide, optional single-cycle multiply.
// Latency 1 (fast mul, div specials) or XLEN+1; result held in DONE until out_ready, accepts only in IDLE.
module exu_muldiv #(
    parameter int XLEN     = 32,
    parameter int MUL_FAST = 0
) (
    input logic          clk,
    input logic          rst,
    exu_muldiv_if.slave  io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   b_mag;
    logic              sa_q, sb_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_q;

    logic              accept;
    logic              rs1_signed, rs2_signed, sa_in, sb_in;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic              div0, ovf, fast;
    logic [2*XLEN-1:0] fast_prod_u, fast_prod;
    logic [XLEN-1:0]   imm_res;

    assign io.in_ready  = (state == S_IDLE);
    assign io.busy      = (state != S_IDLE);
    assign io.out_valid = (state == S_DONE);
    assign io.result    = result_q;
    assign io.rd_out    = rd_q;

    // flush in IDLE suppresses acceptance
    assign accept = io.in_valid && (state == S_IDLE) && !io.flush;

    assign rs1_signed = (io.op == 3'd1) || (io.op == 3'd2) || (io.op == 3'd4) || (io.op == 3'd6);
    assign rs2_signed = (io.op == 3'd1) || (io.op == 3'd4) || (io.op == 3'd6);
    assign sa_in      = rs1_signed && io.rs1_data[XLEN-1];
    assign sb_in      = rs2_signed && io.rs2_data[XLEN-1];
    assign a_mag_in   = sa_in ? -io.rs1_data : io.rs1_data;
    assign b_mag_in   = sb_in ? -io.rs2_data : io.rs2_data;

    assign div0 = io.op[2] && (io.rs2_data == '0);
    assign ovf  = ((io.op == 3'd4) || (io.op == 3'd6)) && (io.rs1_data == XMIN) && (io.rs2_data == '1);
    assign fast = (MUL_FAST != 0) && !io.op[2];

    assign fast_prod_u = {{XLEN{1'b0}}, a_mag_in} * {{XLEN{1'b0}}, b_mag_in};
    assign fast_prod   = (sa_in ^ sb_in) ? -fast_prod_u : fast_prod_u;

    always_comb begin
        imm_res = '0;
        if (div0)
            imm_res = io.op[1] ? io.rs1_data : '1;
        else if (ovf)
            imm_res = io.op[1] ? '0 : io.rs1_data;
        else if (io.op[1:0] == 2'd0)
            imm_res = fast_prod[XLEN-1:0];
        else
            imm_res = fast_prod[2*XLEN-1:XLEN];
    end

    // Iteration step: acc = {hi, lo}; hi is product-high / partial remainder, lo is multiplier / quotient.
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : {(XLEN+1){1'b0}});
    assign mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, b_mag};
    assign div_nxt  = rem_diff[XLEN] ? {rem_sh[XLEN-1:0],   acc[XLEN-2:0], 1'b0}
                                     : {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign acc_nxt  = op_q[2] ? div_nxt : mul_nxt;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

    assign prod_fix = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
    assign quo_fix  = (sa_q ^ sb_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    assign rem_fix  = sa_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

    always_comb begin
        calc_res = rem_fix;
        case (op_q)
            3'd0:             calc_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: calc_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       calc_res = quo_fix;
            default:          calc_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            b_mag    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= io.op;
                        rd_q  <= io.rd_in;
                        b_mag <= b_mag_in;
                        sa_q  <= sa_in;
                        sb_q  <= sb_in;
                        acc   <= {{XLEN{1'b0}}, a_mag_in};
                        if (div0 || ovf || fast) begin
                            result_q <= imm_res;
                            state    <= S_DONE;
                        end else begin
                            cnt   <= CW'(XLEN);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (io.flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            result_q <= calc_res;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (io.flush || io.out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_muldiv.sv
// Directed bench for exu_muldiv: runs an iterative (MUL_FAST=0) and a fast-multiply (MUL_FAST=1) instance side by side.
module tb_exu_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exu_muldiv_if #(.XLEN(32)) if0 ();
    exu_muldiv_if #(.XLEN(32)) if1 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.op       = op;        assign if1.op       = op;
    assign if0.rs1_data = rs1;       assign if1.rs1_data = rs1;
    assign if0.rs2_data = rs2;       assign if1.rs2_data = rs2;
    assign if0.rd_in    = rd_in;     assign if1.rd_in    = rd_in;
    assign if0.flush    = flush;     assign if1.flush    = flush;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

    exu_muldiv #(.XLEN(32), .MUL_FAST(0)) u_dut0 (.clk(clk), .rst(rst), .io(if0));
    exu_muldiv #(.XLEN(32), .MUL_FAST(1)) u_dut1 (.clk(clk), .rst(rst), .io(if1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(if0.in_ready && if1.in_ready) && n < 80) begin
            tick();
            n++;
        end
        chk("idle_wait", (n < 80), 1);
    endtask

    // Issue one op to both units; latency counts the accept edge as 1.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input logic sp);
        int lat0, lat1, n;
        logic [31:0] r0, r1;
        logic [4:0]  d0, d1;
        lat0 = 0; lat1 = 0; r0 = '0; r1 = '0; d0 = '0; d1 = '0;
        wait_idle();
        op = o; rs1 = a; rs2 = b; rd_in = rd; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (n <= 40 && (lat0 == 0 || lat1 == 0)) begin
            if (lat0 == 0 && if0.out_valid) begin lat0 = n; r0 = if0.result; d0 = if0.rd_out; end
            if (lat1 == 0 && if1.out_valid) begin lat1 = n; r1 = if1.result; d1 = if1.rd_out; end
            if (lat0 == 0 || lat1 == 0) tick();
            n++;
        end
        chk({tag, "_res0"}, r0, exp);
        chk({tag, "_res1"}, r1, exp);
        chk({tag, "_lat0"}, lat0, sp ? 1 : 33);
        chk({tag, "_lat1"}, lat1, (sp || o < 3'd4) ? 1 : 33);
        chk({tag, "_rd0"}, d0, rd);
        chk({tag, "_rd1"}, d1, rd);
        tick();
    endtask

    initial begin
        int hits;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_result", if0.result, 0);
        chk("rst_rd_out", if0.rd_out, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_in_ready", if0.in_ready, 1);

        // multiplies
        run_op("mul_7xm3",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
        run_op("mul_shift",   3'd0, 32'h1234_5678,  32'h0000_0010, 5'd6,  32'h2345_6780, 1'b0);
        run_op("mulh_min",    3'd1, 32'h8000_0000,  32'h8000_0000, 5'd7,  32'h4000_0000, 1'b0);
        run_op("mulh_m1m1",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 1'b0);
        run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu_max",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF, 1'b0);
        // divides
        run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFF, 1'b0);
        run_op("div_7_m2",    3'd4, 32'd7,          32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_7_m2",    3'd6, 32'd7,          32'hFFFF_FFFE, 5'd14, 32'h0000_0001, 1'b0);
        run_op("divu_100_7",  3'd5, 32'd100,        32'd7,         5'd15, 32'd14,        1'b0);
        run_op("remu_100_7",  3'd7, 32'd100,        32'd7,         5'd16, 32'd2,         1'b0);
        // special cases
        run_op("divu_by0",    3'd5, 32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF, 1'b1);
        run_op("remu_by0",    3'd7, 32'd5,          32'd0,         5'd18, 32'd5,         1'b1);
        run_op("div_by0",     3'd4, 32'hFFFF_FFFB,  32'd0,         5'd19, 32'hFFFF_FFFF, 1'b1);
        run_op("rem_by0",     3'd6, 32'hFFFF_FFFB,  32'd0,         5'd20, 32'hFFFF_FFFB, 1'b1);
        run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1'b1);
        run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd22, 32'h0000_0000, 1'b1);

        // backpressure: result held, next op only accepted after release
        wait_idle();
        out_ready = 1'b0;
        op = 3'd5; rs1 = 32'd5; rs2 = 32'd0; rd_in = 5'd3; in_valid = 1'b1;
        tick();
        op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd9;
        chk("bp_valid", if0.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_res", if0.result, 32'hFFFF_FFFF);
            chk("bp_hold_rd", if0.rd_out, 3);
            chk("bp_in_ready", if0.in_ready, 0);
            chk("bp_busy", if0.busy, 1);
            tick();
        end
        chk("bp_still_valid", if0.out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_valid", if0.out_valid, 0);
        chk("bp_rel_ready", if0.in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_acc", if0.busy, 1);
        chk("bp_next_ready", if0.in_ready, 0);
        hits = 0;
        while (!if0.out_valid && hits < 40) begin tick(); hits++; end
        chk("bp_next_res", if0.result, 32'd14);
        chk("bp_next_rd", if0.rd_out, 9);
        tick();

        // flush in CALC cycle 10
        wait_idle();
        op = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd_in = 5'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("fl_in_calc", if0.busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_ready", if0.in_ready, 1);
        chk("fl_valid", if0.out_valid, 0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (if0.out_valid) hits++;
            tick();
        end
        chk("fl_no_result", hits, 0);

        // flush with in_valid in IDLE: no accept
        wait_idle();
        op = 3'd5; rs1 = 32'd5; rs2 = 32'd0; rd_in = 5'd4; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_idle_valid", if0.out_valid, 0);
        chk("fl_idle_busy", if0.busy, 0);
        chk("fl_idle_ready", if0.in_ready, 1);

        // reset while in DONE
        out_ready = 1'b0;
        op = 3'd5; rs1 = 32'd5; rs2 = 32'd0; rd_in = 5'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rd_done_valid", if0.out_valid, 1);
        chk("rd_done_res", if0.result, 32'hFFFF_FFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rd_rst_valid", if0.out_valid, 0);
        chk("rd_rst_result", if0.result, 0);
        chk("rd_rst_rd", if0.rd_out, 0);
        chk("rd_rst_ready", if0.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
